// File: rtl/regfile_bypass_sb_if.sv
// Bundle of read, write-back and issue signals for the bypassing register
// file with busy scoreboard. master = decode/writeback side, slave = regfile.
interface regfile_bypass_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    localparam int AW = $clog2(NUM_REGS);

    // Read ports (combinational data and busy status)
    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic            rd_busy1;
    logic            rd_busy2;

    // Two writeback lanes
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;

    // Issue / scoreboard
    logic            issue_valid;
    logic [AW-1:0]   issue_addr;
    logic            issue_stall;
    logic [AW:0]     busy_count;

    modport master (
        output rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2,
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output issue_valid, issue_addr,
        input  issue_stall, busy_count
    );

    modport slave (
        input  rd_addr1, rd_addr2,
        output rd_data1, rd_data2, rd_busy1, rd_busy2,
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  issue_valid, issue_addr,
        output issue_stall, busy_count
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Register file with two combinational read ports, two write lanes
// (lane 0 has priority), optional same-cycle write-to-read bypass and a
// per-register busy scoreboard used for RAW/WAW hazard detection.
module regfile_bypass_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_bypass_sb_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     data_q [NUM_REGS];
    logic [XLEN-1:0]     data_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;

    logic wr0_eff;
    logic wr1_eff;
    logic issue_hit_wr;
    logic issue_stall;
    logic issue_acc;

    // Writes to x0 are not "effective" when it is hardwired; this keeps
    // bypass, busy-clear and storage logic free of special cases.
    assign wr0_eff = bus.we0 & ~((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign wr1_eff = bus.we1 & ~((ZERO_REG != 0) && (bus.waddr1 == '0));

    // A write landing on the issue target this cycle clears its busy bit,
    // so the issue may proceed (WAW resolved by the retiring producer).
    assign issue_hit_wr = (wr0_eff && (bus.waddr0 == bus.issue_addr)) ||
                          (wr1_eff && (bus.waddr1 == bus.issue_addr));
    assign issue_stall  = bus.issue_valid & busy_q[bus.issue_addr] & ~issue_hit_wr;
    assign issue_acc    = bus.issue_valid & ~issue_stall &
                          ~((ZERO_REG != 0) && (bus.issue_addr == '0));

    // Per-register next state: lane 0 beats lane 1, issue beats clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic hit0;
            logic hit1;
            logic set;
            assign hit0       = wr0_eff && (bus.waddr0 == IDX);
            assign hit1       = wr1_eff && (bus.waddr1 == IDX);
            assign set        = issue_acc && (bus.issue_addr == IDX);
            assign data_d[gi] = hit0 ? bus.wdata0 : (hit1 ? bus.wdata1 : data_q[gi]);
            assign busy_d[gi] = set | (busy_q[gi] & ~(hit0 | hit1));
        end
    endgenerate

    // Busy count tracks the population of the next busy bitmap exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d = count_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // State registers; reset overrides any same-cycle write or issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Read ports share one implementation, indexed by port number.
    logic [AW-1:0]   rd_addr   [2];
    logic [XLEN-1:0] rd_data_p [2];
    logic            rd_busy_p [2];

    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            // Stored value, overlaid with lane 1 then lane 0 forwarding.
            always_comb begin
                rd_data_p[gi] = data_q[rd_addr[gi]];
                rd_busy_p[gi] = busy_q[rd_addr[gi]];
                if (BYPASS != 0) begin
                    if (wr1_eff && (bus.waddr1 == rd_addr[gi])) begin
                        rd_data_p[gi] = bus.wdata1;
                        rd_busy_p[gi] = 1'b0;
                    end
                    if (wr0_eff && (bus.waddr0 == rd_addr[gi])) begin
                        rd_data_p[gi] = bus.wdata0;
                        rd_busy_p[gi] = 1'b0;
                    end
                end
                if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                    rd_data_p[gi] = '0;
                    rd_busy_p[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign bus.rd_data1    = rd_data_p[0];
    assign bus.rd_data2    = rd_data_p[1];
    assign bus.rd_busy1    = rd_busy_p[0];
    assign bus.rd_busy2    = rd_busy_p[1];
    assign bus.issue_stall = issue_stall;
    assign bus.busy_count  = count_q;

endmodule
